// File: rtl/rob_queue_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// rob_queue_if : allocate / writeback / commit bundle for rob_queue.
// Revision 1.0
// ------------------------------------------------------------------------
interface rob_queue_if #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int EXC_WIDTH     = 4
);
  logic                     flush;

  logic                     alloc_en;
  logic                     alloc_ready;
  logic [ADDR_WIDTH-1:0]    alloc_id;
  logic                     alloc_reg_write_add;
  logic                     alloc_reg_write_en;
  logic                     alloc_reg_write_lo_en;
  logic [RF_ADDR_WIDTH-1:0] alloc_reg_write_addr;
  logic [EXC_WIDTH-1:0]     alloc_exc_type;
  logic                     alloc_is_delayslot;
  logic [DATA_WIDTH-1:0]    alloc_pc;

  logic                     wb_en;
  logic [ADDR_WIDTH-1:0]    wb_id;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic [DATA_WIDTH-1:0]    wb_lo_data;
  logic [EXC_WIDTH-1:0]     wb_exc_type;

`ifdef ROB_DUAL_WB_EN
  logic                     wb2_en;
  logic [ADDR_WIDTH-1:0]    wb2_id;
  logic [DATA_WIDTH-1:0]    wb2_data;
  logic [DATA_WIDTH-1:0]    wb2_lo_data;
  logic [EXC_WIDTH-1:0]     wb2_exc_type;
`endif

  logic                     commit_valid;
  logic                     commit_en;
  logic                     commit_reg_write_add;
  logic                     commit_reg_write_en;
  logic                     commit_reg_write_lo_en;
  logic [RF_ADDR_WIDTH-1:0] commit_reg_write_addr;
  logic [DATA_WIDTH-1:0]    commit_reg_write_data;
  logic [DATA_WIDTH-1:0]    commit_reg_write_lo_data;
  logic [EXC_WIDTH-1:0]     commit_exc_type;
  logic                     commit_is_delayslot;
  logic [DATA_WIDTH-1:0]    commit_pc;
  logic [ADDR_WIDTH:0]      count;

  modport master (
`ifdef ROB_DUAL_WB_EN
    output wb2_en, wb2_id, wb2_data, wb2_lo_data, wb2_exc_type,
`endif
    output flush, alloc_en, alloc_reg_write_add, alloc_reg_write_en,
           alloc_reg_write_lo_en, alloc_reg_write_addr, alloc_exc_type,
           alloc_is_delayslot, alloc_pc,
           wb_en, wb_id, wb_data, wb_lo_data, wb_exc_type, commit_en,
    input  alloc_ready, alloc_id, commit_valid, commit_reg_write_add,
           commit_reg_write_en, commit_reg_write_lo_en, commit_reg_write_addr,
           commit_reg_write_data, commit_reg_write_lo_data, commit_exc_type,
           commit_is_delayslot, commit_pc, count
  );

  modport slave (
`ifdef ROB_DUAL_WB_EN
    input  wb2_en, wb2_id, wb2_data, wb2_lo_data, wb2_exc_type,
`endif
    input  flush, alloc_en, alloc_reg_write_add, alloc_reg_write_en,
           alloc_reg_write_lo_en, alloc_reg_write_addr, alloc_exc_type,
           alloc_is_delayslot, alloc_pc,
           wb_en, wb_id, wb_data, wb_lo_data, wb_exc_type, commit_en,
    output alloc_ready, alloc_id, commit_valid, commit_reg_write_add,
           commit_reg_write_en, commit_reg_write_lo_en, commit_reg_write_addr,
           commit_reg_write_data, commit_reg_write_lo_data, commit_exc_type,
           commit_is_delayslot, commit_pc, count
  );
endinterface
`default_nettype wire

// File: rtl/rob_queue.sv
`default_nettype none
// ------------------------------------------------------------------------
// rob_queue : reorder buffer, in-order alloc/retire, out-of-order writeback.
// Define ROB_DUAL_WB_EN for a second writeback port (port 1 wins on clash).
// Revision 1.0
// ------------------------------------------------------------------------
module rob_queue #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int EXC_WIDTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  rob_queue_if.slave rob
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [ADDR_WIDTH:0]      head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]         valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0]         add_q, add_d, wen_q, wen_d, loen_q, loen_d, ds_q, ds_d;
  logic [RF_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [RF_ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [EXC_WIDTH-1:0]     exc_q  [DEPTH];
  logic [EXC_WIDTH-1:0]     exc_d  [DEPTH];
  logic [DATA_WIDTH-1:0]    pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    pc_d   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_d [DEPTH];
  logic [DATA_WIDTH-1:0]    lo_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    lo_d   [DEPTH];

  logic [ADDR_WIDTH-1:0] head_idx, tail_idx;
  logic                  full, alloc_fire, commit_valid, commit_fire, wb_hit;

  assign head_idx     = head_q[ADDR_WIDTH-1:0];
  assign tail_idx     = tail_q[ADDR_WIDTH-1:0];
  assign full         = (head_idx == tail_idx) && (head_q[ADDR_WIDTH] != tail_q[ADDR_WIDTH]);
  assign alloc_fire   = rob.alloc_en && !full;
  assign commit_valid = valid_q[head_idx] && done_q[head_idx];
  assign commit_fire  = commit_valid && rob.commit_en;

  // A writeback to the entry retiring this cycle is dropped: the retire clears it.
  assign wb_hit = rob.wb_en && valid_q[rob.wb_id] && !(commit_fire && (rob.wb_id == head_idx));

`ifdef ROB_DUAL_WB_EN
  logic wb2_hit;
  assign wb2_hit = rob.wb2_en && valid_q[rob.wb2_id]
                && !(commit_fire && (rob.wb2_id == head_idx))
                && !(wb_hit && (rob.wb2_id == rob.wb_id));
`endif

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    add_d   = add_q;
    wen_d   = wen_q;
    loen_d  = loen_q;
    ds_d    = ds_q;
    addr_d  = addr_q;
    exc_d   = exc_q;
    pc_d    = pc_q;
    data_d  = data_q;
    lo_d    = lo_q;

`ifdef ROB_DUAL_WB_EN
    if (wb2_hit) begin
      data_d[rob.wb2_id] = rob.wb2_data;
      lo_d[rob.wb2_id]   = rob.wb2_lo_data;
      done_d[rob.wb2_id] = 1'b1;
      if (rob.wb2_exc_type != '0) exc_d[rob.wb2_id] = rob.wb2_exc_type;
    end
`endif

    if (wb_hit) begin
      data_d[rob.wb_id] = rob.wb_data;
      lo_d[rob.wb_id]   = rob.wb_lo_data;
      done_d[rob.wb_id] = 1'b1;
      if (rob.wb_exc_type != '0) exc_d[rob.wb_id] = rob.wb_exc_type;
    end

    if (commit_fire) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + PTR_ONE;
    end

    // Entries carrying a pre-issue exception never see a writeback, so they start done.
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = (rob.alloc_exc_type != '0);
      add_d[tail_idx]   = rob.alloc_reg_write_add;
      wen_d[tail_idx]   = rob.alloc_reg_write_en;
      loen_d[tail_idx]  = rob.alloc_reg_write_lo_en;
      ds_d[tail_idx]    = rob.alloc_is_delayslot;
      addr_d[tail_idx]  = rob.alloc_reg_write_addr;
      exc_d[tail_idx]   = rob.alloc_exc_type;
      pc_d[tail_idx]    = rob.alloc_pc;
      data_d[tail_idx]  = '0;
      lo_d[tail_idx]    = '0;
      tail_d            = tail_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || rob.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload is only observed through valid entries, so it carries no reset.
  always_ff @(posedge clk) begin
    add_q  <= add_d;
    wen_q  <= wen_d;
    loen_q <= loen_d;
    ds_q   <= ds_d;
    addr_q <= addr_d;
    exc_q  <= exc_d;
    pc_q   <= pc_d;
    data_q <= data_d;
    lo_q   <= lo_d;
  end

  assign rob.alloc_ready              = !full;
  assign rob.alloc_id                 = tail_idx;
  assign rob.count                    = tail_q - head_q;
  assign rob.commit_valid             = commit_valid;
  assign rob.commit_reg_write_add     = commit_valid & add_q[head_idx];
  assign rob.commit_reg_write_en      = commit_valid & wen_q[head_idx];
  assign rob.commit_reg_write_lo_en   = commit_valid & loen_q[head_idx];
  assign rob.commit_is_delayslot      = commit_valid & ds_q[head_idx];
  assign rob.commit_reg_write_addr    = commit_valid ? addr_q[head_idx] : '0;
  assign rob.commit_exc_type          = commit_valid ? exc_q[head_idx]  : '0;
  assign rob.commit_pc                = commit_valid ? pc_q[head_idx]   : '0;
  assign rob.commit_reg_write_data    = commit_valid ? data_q[head_idx] : '0;
  assign rob.commit_reg_write_lo_data = commit_valid ? lo_q[head_idx]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_rob_queue.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_rob_queue : randomized bench for rob_queue against a queue-based model.
// Revision 1.0
// ------------------------------------------------------------------------
module tb_rob_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial forever #5 clk = ~clk;

  rob_queue_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RF_ADDR_WIDTH(5), .EXC_WIDTH(4)) rif ();

  rob_queue #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RF_ADDR_WIDTH(5), .EXC_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .rob (rif)
  );

  // Model: the occupied entries in program order; m_head is the id of mq[0].
  typedef struct packed {
    logic        add;
    logic        en;
    logic        lo_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] lo;
    logic [3:0]  exc;
    logic        ds;
    logic [31:0] pc;
    logic        done;
  } ent_t;

  ent_t mq[$];
  int   m_head = 0;

  function automatic logic m_cv();
    return (mq.size() > 0) && mq[0].done;
  endfunction

  function automatic logic [119:0] exp_vec();
    ent_t e;
    e = '0;
    if (m_cv()) e = mq[0];
    return {5'(mq.size()), 1'(mq.size() < 16), 4'((m_head + mq.size()) % 16), m_cv(),
            e.add, e.en, e.lo_en, e.addr, e.data, e.lo, e.exc, e.ds, e.pc};
  endfunction

  function automatic logic [119:0] dut_vec();
    return {rif.count, rif.alloc_ready, rif.alloc_id, rif.commit_valid,
            rif.commit_reg_write_add, rif.commit_reg_write_en, rif.commit_reg_write_lo_en,
            rif.commit_reg_write_addr, rif.commit_reg_write_data, rif.commit_reg_write_lo_data,
            rif.commit_exc_type, rif.commit_is_delayslot, rif.commit_pc};
  endfunction

  task automatic model_step();
    int   sz;
    int   idx;
    logic ret;
    ent_t e;
    if (!rst || rif.flush) begin
      mq.delete();
      m_head = 0;
      return;
    end
    sz  = mq.size();
    ret = m_cv() && rif.commit_en;
    if (rif.wb_en) begin
      idx = (int'(rif.wb_id) - m_head + 16) % 16;
      if (idx < sz && !(ret && idx == 0)) begin
        mq[idx].data = rif.wb_data;
        mq[idx].lo   = rif.wb_lo_data;
        mq[idx].done = 1'b1;
        if (rif.wb_exc_type != 4'd0) mq[idx].exc = rif.wb_exc_type;
      end
    end
    if (ret) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % 16;
    end
    if (rif.alloc_en && sz < 16) begin
      e.add   = rif.alloc_reg_write_add;
      e.en    = rif.alloc_reg_write_en;
      e.lo_en = rif.alloc_reg_write_lo_en;
      e.addr  = rif.alloc_reg_write_addr;
      e.data  = '0;
      e.lo    = '0;
      e.exc   = rif.alloc_exc_type;
      e.ds    = rif.alloc_is_delayslot;
      e.pc    = rif.alloc_pc;
      e.done  = (rif.alloc_exc_type != 4'd0);
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rif.flush                 = 1'b0;
    rif.alloc_en              = 1'b0;
    rif.alloc_reg_write_add   = 1'b0;
    rif.alloc_reg_write_en    = 1'b0;
    rif.alloc_reg_write_lo_en = 1'b0;
    rif.alloc_reg_write_addr  = '0;
    rif.alloc_exc_type        = '0;
    rif.alloc_is_delayslot    = 1'b0;
    rif.alloc_pc              = '0;
    rif.wb_en                 = 1'b0;
    rif.wb_id                 = '0;
    rif.wb_data               = '0;
    rif.wb_lo_data            = '0;
    rif.wb_exc_type           = '0;
    rif.commit_en             = 1'b0;
`ifdef ROB_DUAL_WB_EN
    rif.wb2_en                = 1'b0;
    rif.wb2_id                = '0;
    rif.wb2_data              = '0;
    rif.wb2_lo_data           = '0;
    rif.wb2_exc_type          = '0;
`endif
  endtask

  task automatic drive_alloc(input logic [3:0] exc, input logic [31:0] pc);
    rif.alloc_en              = 1'b1;
    rif.alloc_reg_write_add   = 1'($urandom);
    rif.alloc_reg_write_en    = 1'($urandom);
    rif.alloc_reg_write_lo_en = 1'($urandom);
    rif.alloc_reg_write_addr  = 5'($urandom);
    rif.alloc_is_delayslot    = 1'($urandom);
    rif.alloc_exc_type        = exc;
    rif.alloc_pc              = pc;
  endtask

  task automatic drive_wb(input logic [3:0] id, input logic [31:0] d, input logic [3:0] exc);
    rif.wb_en       = 1'b1;
    rif.wb_id       = id;
    rif.wb_data     = d;
    rif.wb_lo_data  = ~d;
    rif.wb_exc_type = exc;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_checks++; if (rif.count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", rif.count); else n_pass++;
    n_checks++; if (rif.alloc_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", rif.alloc_ready); else n_pass++;
    n_checks++; if (rif.alloc_id !== 4'd0) $display("FAIL reset_alloc_id got=%0d exp=0", rif.alloc_id); else n_pass++;
    n_checks++; if (rif.commit_valid !== 1'b0) $display("FAIL reset_commit_valid got=%b exp=0", rif.commit_valid); else n_pass++;
    n_checks++; if (rif.commit_pc !== 32'd0) $display("FAIL reset_commit_pc got=%h exp=0", rif.commit_pc); else n_pass++;
    n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL reset_vec got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(4'd0, $urandom);
      n_checks++; if (rif.alloc_id !== 4'(i)) $display("FAIL fill_alloc_id got=%0d exp=%0d", rif.alloc_id, i); else n_pass++;
      tick();
    end
    n_checks++; if (rif.count !== 5'd16) $display("FAIL fill_count got=%0d exp=16", rif.count); else n_pass++;
    n_checks++; if (rif.alloc_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", rif.alloc_ready); else n_pass++;
    drive_alloc(4'd0, 32'h1234_5678);
    tick();
    idle();
    n_checks++; if (rif.count !== 5'd16) $display("FAIL fill_17th_count got=%0d exp=16", rif.count); else n_pass++;
    n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL fill_vec got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
  endtask

  task automatic test_ooo_wb();
    logic [31:0] exp_d [3];
    exp_d = '{32'hA0, 32'hA1, 32'hA2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(4'd0, 32'h100 + 32'(4 * i));
      tick();
    end
    idle();
    drive_wb(4'd2, 32'hA2, 4'd0);
    tick();
    n_checks++; if (rif.commit_valid !== 1'b0) $display("FAIL ooo_cv_after_wb2 got=%b exp=0", rif.commit_valid); else n_pass++;
    drive_wb(4'd0, 32'hA0, 4'd0);
    n_checks++; if (rif.commit_valid !== 1'b0) $display("FAIL ooo_cv_same_cycle got=%b exp=0", rif.commit_valid); else n_pass++;
    tick();
    drive_wb(4'd1, 32'hA1, 4'd0);
    rif.commit_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rif.commit_valid !== 1'b1 || rif.commit_reg_write_data !== exp_d[i])
        $display("FAIL ooo_commit_%0d got=%b/%h exp=1/%h", i, rif.commit_valid, rif.commit_reg_write_data, exp_d[i]);
      else n_pass++;
      n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL ooo_vec_%0d got=%h exp=%h", i, dut_vec(), exp_vec()); else n_pass++;
      tick();
      rif.wb_en = 1'b0;
    end
    idle();
    n_checks++; if (rif.count !== 5'd0 || rif.commit_valid !== 1'b0)
      $display("FAIL ooo_drained got=%0d/%b exp=0/0", rif.count, rif.commit_valid); else n_pass++;
  endtask

  task automatic test_exc();
    do_reset();
    drive_alloc(4'd3, 32'hBFC0_0010);
    tick();
    idle();
    n_checks++; if (rif.commit_valid !== 1'b1) $display("FAIL exc_cv got=%b exp=1", rif.commit_valid); else n_pass++;
    n_checks++; if (rif.commit_exc_type !== 4'd3) $display("FAIL exc_type got=%0d exp=3", rif.commit_exc_type); else n_pass++;
    n_checks++; if (rif.commit_pc !== 32'hBFC0_0010) $display("FAIL exc_pc got=%h exp=bfc00010", rif.commit_pc); else n_pass++;
    rif.commit_en = 1'b1;
    tick();
    idle();
    n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL exc_vec got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
  endtask

  task automatic test_full_alloc_commit();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(4'd0, $urandom);
      tick();
    end
    idle();
    drive_wb(4'd0, $urandom, 4'd0);
    tick();
    idle();
    drive_alloc(4'd0, $urandom);
    rif.commit_en = 1'b1;
    tick();
    idle();
    n_checks++; if (rif.count !== 5'd15) $display("FAIL full_alloc_commit_count got=%0d exp=15", rif.count); else n_pass++;
    n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL full_alloc_commit_vec got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
    drive_alloc(4'd0, $urandom);
    tick();
    idle();
    n_checks++; if (rif.count !== 5'd16) $display("FAIL full_refill_count got=%0d exp=16", rif.count); else n_pass++;
  endtask

  task automatic test_stream_wrap();
    int allocs = 0;
    int cyc    = 0;
    int pick;
    do_reset();
    while (allocs < 40 && cyc < 600) begin
      idle();
      if ($urandom % 4 != 0) drive_alloc(($urandom % 5 == 0) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom);
      if (mq.size() > 0 && $urandom % 3 != 0) begin
        pick = $urandom_range(0, mq.size() - 1);
        drive_wb(4'((m_head + pick) % 16), $urandom, ($urandom % 6 == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      end
      rif.commit_en = ($urandom % 3 != 0);
      if (rif.alloc_en && mq.size() < 16) begin
        n_checks++; if (rif.alloc_id !== 4'(allocs % 16))
          $display("FAIL stream_alloc_id got=%0d exp=%0d", rif.alloc_id, allocs % 16); else n_pass++;
        allocs++;
      end
      tick();
      cyc++;
      n_checks++; if (rif.count > 5'd16) $display("FAIL stream_count_bound got=%0d exp<=16", rif.count); else n_pass++;
      n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL stream_vec cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); else n_pass++;
    end
    n_checks++; if (allocs < 40) $display("FAIL stream_progress got=%0d exp=40", allocs); else n_pass++;
    cyc = 0;
    while (mq.size() > 0 && cyc < 200) begin
      idle();
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].done) begin
          drive_wb(4'((m_head + i) % 16), $urandom, 4'd0);
          break;
        end
      end
      rif.commit_en = 1'b1;
      tick();
      cyc++;
      n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL drain_vec got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
    end
    idle();
    n_checks++; if (rif.count !== 5'd0) $display("FAIL drain_count got=%0d exp=0", rif.count); else n_pass++;
  endtask

  task automatic test_flush(input bit use_rst);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(4'd0, $urandom);
      tick();
    end
    idle();
    drive_wb(4'd0, $urandom, 4'd0);
    tick();
    drive_wb(4'd3, $urandom, 4'd0);
    tick();
    drive_alloc(4'd0, $urandom);
    drive_wb(4'd1, $urandom, 4'd0);
    if (use_rst) rst = 1'b0;
    else rif.flush = 1'b1;
    tick();
    rst = 1'b1;
    idle();
    n_checks++; if (rif.count !== 5'd0) $display("FAIL flush%0d_count got=%0d exp=0", use_rst, rif.count); else n_pass++;
    n_checks++; if (rif.commit_valid !== 1'b0) $display("FAIL flush%0d_cv got=%b exp=0", use_rst, rif.commit_valid); else n_pass++;
    n_checks++; if (rif.alloc_id !== 4'd0) $display("FAIL flush%0d_alloc_id got=%0d exp=0", use_rst, rif.alloc_id); else n_pass++;
    drive_wb(4'd3, 32'hDEAD_BEEF, 4'd0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(4'd0, $urandom);
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      drive_wb(4'(k), $urandom, 4'd0);
      tick();
      idle();
      rif.commit_en = 1'b1;
      tick();
      idle();
      n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL flush%0d_vec_%0d got=%h exp=%h", use_rst, k, dut_vec(), exp_vec()); else n_pass++;
    end
    n_checks++; if (rif.commit_valid !== 1'b0 || rif.count !== 5'd1)
      $display("FAIL flush%0d_stale_wb got=%b/%0d exp=0/1", use_rst, rif.commit_valid, rif.count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      idle();
      if ($urandom % 3 != 0) drive_alloc(($urandom % 6 == 0) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom);
      if ($urandom % 2 == 0) begin
        if (mq.size() > 0 && $urandom % 4 != 0)
          drive_wb(4'((m_head + $urandom_range(0, mq.size() - 1)) % 16), $urandom, ($urandom % 5 == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
        else
          drive_wb(4'($urandom), $urandom, 4'd0);
      end
      rif.commit_en = ($urandom % 2 == 0);
      if ($urandom % 40 == 0) begin
        rif.flush     = 1'b1;
        rif.commit_en = 1'b0;
      end
      tick();
      n_checks++; if (dut_vec() !== exp_vec()) $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_ooo_wb();
    test_exc();
    test_full_alloc_commit();
    test_stream_wrap();
    test_flush(1'b0);
    test_flush(1'b1);
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=%0d/%0d checks exp=completion", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rob_queue.md
Name: rob_queue

Overview:
Parametrised reorder buffer storage with a single allocate, single (optionally dual) writeback and single commit channel. Sits between issue logic (allocate, writeback from execution units) and the commit/regfile/exception path. Entries are allocated in program order, completed out of order by ROB id, and retired in order from the head.
Replaces external fixed-size ROB storage. Adds depth/width generics, a flush, and an occupancy count.

Parameters:
ADDR_WIDTH, 4, log2 of entry count (depth = 2**ADDR_WIDTH)
DATA_WIDTH, 32, width of result data and PC
RF_ADDR_WIDTH, 5, register file address width
EXC_WIDTH, 4, exception type width; value 0 = no exception

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
flush  in  1  discard all entries
alloc_en  in  1  allocate request
alloc_ready  out  1  entry available (not full)
alloc_id  out  ADDR_WIDTH  id given to the allocated entry (tail)
alloc_reg_write_add / alloc_reg_write_en / alloc_reg_write_lo_en  in  1 each  commit-time regfile controls
alloc_reg_write_addr  in  RF_ADDR_WIDTH  destination register
alloc_exc_type  in  EXC_WIDTH  exception detected before issue
alloc_is_delayslot  in  1  delay-slot flag
alloc_pc  in  DATA_WIDTH  instruction PC
wb_en  in  1  result writeback
wb_id  in  ADDR_WIDTH  target entry
wb_data / wb_lo_data  in  DATA_WIDTH  result / LO result
wb_exc_type  in  EXC_WIDTH  exception raised during execution
commit_valid  out  1  head entry complete
commit_en  in  1  consumer retires head
commit_reg_write_add / commit_reg_write_en / commit_reg_write_lo_en  out  1 each
commit_reg_write_addr  out  RF_ADDR_WIDTH
commit_reg_write_data / commit_reg_write_lo_data  out  DATA_WIDTH
commit_exc_type  out  EXC_WIDTH
commit_is_delayslot  out  1
commit_pc  out  DATA_WIDTH
count  out  ADDR_WIDTH+1  occupied entries

Behaviour:
- Head/tail pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit. Empty: head==tail. Full: low bits equal, MSBs differ. count = tail-head (mod 2**(ADDR_WIDTH+1)).
- Per-entry state: valid, done, plus the stored fields.
- Reset (rst=0 at clk edge): head=tail=0, all valid/done=0.
  - Resulting outputs: alloc_ready=1, alloc_id=0, commit_valid=0, count=0.
  - All commit_* data outputs 0 (gated to 0 while commit_valid=0).
  - Reset mid-operation discards all entries.
- alloc_ready = !full, from registered state only. alloc_id = tail[ADDR_WIDTH-1:0], combinational.
- Allocate, when alloc_en && alloc_ready:
  - Entry at tail is written with the alloc fields; valid=1; result data cleared to 0.
  - done=1 if alloc_exc_type!=0, else done=0.
  - tail increments. No effect while full, even if a commit occurs in the same cycle.
- Writeback, when wb_en and entry wb_id is valid:
  - Stores wb_data and wb_lo_data; done=1.
  - If wb_exc_type!=0 it overwrites the stored exception type; otherwise the allocation-time type is kept.
  - Writeback to an invalid entry is ignored. Writeback to an already-done entry overwrites its data.
- commit_valid = head entry valid && done (registered state). Commit outputs show the head fields.
- Retire, when commit_valid && commit_en: head entry valid=0, done=0; head increments. commit_en with commit_valid=0 is ignored.
- Latency:
  - Allocate to writeback-eligible: next cycle.
  - Writeback to commit_valid: 1 cycle. A writeback to the head entry in cycle N gives commit_valid in N+1, never N.
- Simultaneous events:
  - Alloc, writeback (different entry) and retire are all honoured in one cycle; count is updated by net +1/0/-1.
  - Writeback and retire on the same entry: retire wins (the entry cannot be done-and-written in that cycle, because commit_valid requires done already).
- flush=1 has priority over alloc, writeback and retire in that cycle.
  - Result: head=tail=0 and all valid=0 on the next cycle. The ROB behaves as after reset.
  - Commit outputs are still driven during the flush cycle; the consumer must not assert commit_en with flush.

Optional Feature:
ROB_DUAL_WB_EN: when defined, adds a second writeback port (wb2_en, wb2_id, wb2_data, wb2_lo_data, wb2_exc_type) with rules identical to port 1. If both ports target the same id in one cycle, port 1 wins. When undefined, these ports do not exist and there is a single writeback path.

Test Plan:
1. Reset, then allocate 16 entries (ADDR_WIDTH=4) back-to-back -> alloc_id 0..15, count=16, alloc_ready=0. A 17th alloc_en is ignored (tail unchanged).
2. Allocate ids 0,1,2; write back 2, then 0, then 1 (data 0xA2, 0xA0, 0xA1); hold commit_en=1 -> commits in order 0,1,2 with data 0xA0,0xA1,0xA2. commit_valid first rises one cycle after wb of id 0.
3. Allocate with alloc_exc_type=3, pc=0xBFC00010, no writeback -> commit_valid=1 next cycle, commit_exc_type=3, commit_pc=0xBFC00010.
4. Full ROB with head done; assert alloc_en and commit_en in the same cycle -> retire happens, allocate is refused, count=15. Allocation succeeds the next cycle (count=16).
5. Allocate/retire 40 entries in a steady stream -> correct data across pointer wrap; count never exceeds 16; alloc_id sequence wraps 15 to 0.
6. Mid-stream flush, or rst=0 for one cycle, with 5 entries pending -> next cycle count=0, commit_valid=0, alloc_id=0. A stale writeback to id 3 is then ignored.
